// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into 32-bit words and streams them
// into instruction memory at auto-incrementing word addresses.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           begin a new load session (honoured only when idle)
//   in_valid/ready  field bundle handshake
//   in_fmt          0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal)
//   in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm
//   mem_we/ready    memory write handshake
//   mem_addr        word address of current write
//   mem_wdata       encoded instruction at FIFO head
//   busy            FIFO non-empty
//   count           words written this session (saturating)
//   err             sticky illegal-format flag

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module instr_encoder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_fmt,
    input  logic [6:0]                 in_opcode,
    input  logic [2:0]                 in_funct3,
    input  logic [6:0]                 in_funct7,
    input  logic [`REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [`REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [`REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [`DATA_WIDTH-1:0]     in_imm,
    output logic                       mem_we,
    input  logic                       mem_ready,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [`DATA_WIDTH-1:0]     mem_wdata,
    output logic                       busy,
    output logic [ADDR_WIDTH:0]        count,
    output logic                       err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [PW:0] FULL_OCC = (PW+1)'(FIFO_DEPTH);

    logic [`DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [`DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            occ_q, occ_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic                   err_q, err_d;

    logic                   is_r, is_i, is_s, is_b, is_u, is_j;
    logic                   legal, empty, full;
    logic                   accept, push, bad, pop, start_ok;
    logic [`DATA_WIDTH-1:0] enc;

    assign is_r  = (in_fmt == 3'd0);
    assign is_i  = (in_fmt == 3'd1);
    assign is_s  = (in_fmt == 3'd2);
    assign is_b  = (in_fmt == 3'd3);
    assign is_u  = (in_fmt == 3'd4);
    assign is_j  = (in_fmt == 3'd5);
    assign legal = is_r | is_i | is_s | is_b | is_u | is_j;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == FULL_OCC);

    assign in_ready = !full && !rst;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign bad      = accept && !legal;

    // No write may leave during the reset cycle, even with stale entries.
    assign mem_we    = !empty && !rst;
    assign pop       = mem_we && mem_ready;
    assign mem_wdata = mem_we ? fifo_q[rd_ptr_q] : '0;
    assign mem_addr  = addr_q;
    assign busy      = !empty && !rst;
    assign count     = count_q;
    assign err       = err_q;

    // Empty FIFO means no pop can collide with the session restart.
    assign start_ok = start && empty && !rst;

    always_comb begin
        enc = '0;
        unique case (1'b1)
            is_r: enc = {in_funct7, in_rs2, in_rs1, in_funct3,
                         in_rd, in_opcode};
            is_i: enc = {in_imm[11:0], in_rs1, in_funct3,
                         in_rd, in_opcode};
            is_s: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:0], in_opcode};
            is_b: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                         in_funct3, in_imm[4:1], in_imm[11],
                         in_opcode};
            is_u: enc = {in_imm[31:12], in_rd, in_opcode};
            is_j: enc = {in_imm[20], in_imm[10:1], in_imm[11],
                         in_imm[19:12], in_rd, in_opcode};
            default: enc = '0;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;

        if (push) begin
            fifo_d[wr_ptr_q] = enc;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + 1'b1;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (start_ok) begin
            addr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
        end

        // An illegal bundle in the start cycle belongs to the new session.
        if (bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= BASE;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed bench for instr_encoder
// with a shift-and-mask encoding model and a write-side monitor.

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic [10:0] count;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rnd_rdy  = 0;

    logic [9:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int          wc_q [$];
    logic [31:0] exp_q [$];

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A write completes at the posedge following this sample.
    always @(negedge clk) begin
        if (mem_we && mem_ready) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [31:0] ref_enc(
        input int unsigned fmt, op, f3, f7,
        input int unsigned rs1, rs2, rd, imm);
        int unsigned w;
        int unsigned mid;
        mid = (rs1 << 15) | (f3 << 12) | op;
        case (fmt)
            0: w = (f7 << 25) | (rs2 << 20) | mid | (rd << 7);
            1: w = ((imm & 32'hfff) << 20) | mid | (rd << 7);
            2: w = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20)
                 | mid | ((imm & 32'h1f) << 7);
            3: w = (((imm >> 12) & 1) << 31)
                 | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
                 | mid | (((imm >> 1) & 32'hf) << 8)
                 | (((imm >> 11) & 1) << 7);
            4: w = (imm & 32'hfffff000) | (rd << 7) | op;
            5: w = (((imm >> 20) & 1) << 31)
                 | (((imm >> 1) & 32'h3ff) << 21)
                 | (((imm >> 11) & 1) << 20)
                 | (((imm >> 12) & 32'hff) << 12)
                 | (rd << 7) | op;
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [31:0] im);
        in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = s1; in_rs2 = s2; in_rd = d; in_imm = im;
    endtask

    task automatic rand_fields(input bit allow_bad, output bit legal);
        if (allow_bad) in_fmt = 3'($urandom_range(0, 7));
        else in_fmt = 3'($urandom_range(0, 5));
        in_opcode = 7'($urandom); in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom); in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom); in_rd = 5'($urandom);
        in_imm = $urandom;
        legal = (in_fmt < 3'd6);
    endtask

    function automatic logic [31:0] cur_exp();
        return ref_enc(in_fmt, in_opcode, in_funct3, in_funct7,
                       in_rs1, in_rs2, in_rd, in_imm);
    endfunction

    // Entered and left at posedge+1.
    task automatic send_cur(input string nm);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_checks++;
            $display("FAIL %s handshake timeout", nm);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s drain timeout", nm);
        end
        @(posedge clk); #1;
    endtask

    task automatic new_session();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready);
        else n_pass++;
        n_checks++;
        if ({mem_we, busy, err} !== 3'b000)
            $display("FAIL rst_flags got %b exp 000", {mem_we, busy, err});
        else n_pass++;
        n_checks++;
        if (mem_addr !== 10'd0 || count !== 11'd0 || mem_wdata !== 32'd0)
            $display("FAIL rst_values got addr %0d cnt %0d data %h exp 0",
                     mem_addr, count, mem_wdata);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_r();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        set_fields(0, 7'h33, 0, 0, 1, 2, 3, 0);
        send_cur("r_add");
        drain("r_add");
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'h002081B3)
            $display("FAIL r_add got n %0d addr %0d data %h exp 1 0 002081b3",
                     wa_q.size(), wa_q[0], wd_q[0]);
        else n_pass++;
        n_checks++;
        if (count !== 11'd1) $display("FAIL r_count got %0d exp 1", count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e [3];
        e[0] = 32'h00500093; e[1] = 32'h0020A423; e[2] = 32'h123452B7;
        new_session();
        set_fields(1, 7'h13, 0, 0, 0, 0, 1, 32'd5);
        send_cur("b2b_i");
        set_fields(2, 7'h23, 3'd2, 0, 1, 2, 0, 32'd8);
        send_cur("b2b_s");
        set_fields(4, 7'h37, 0, 0, 0, 0, 5, 32'h12345000);
        send_cur("b2b_u");
        drain("b2b");
        n_checks++;
        if (wa_q.size() != 3) $display("FAIL b2b_n got %0d exp 3", wa_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== 10'(i) || wd_q[i] !== e[i])
                $display("FAIL b2b_word%0d got addr %0d data %h exp %0d %h",
                         i, wa_q[i], wd_q[i], i, e[i]);
            else n_pass++;
        end
        if (wc_q.size() == 3) begin
            n_checks++;
            if (wc_q[1] - wc_q[0] != 1 || wc_q[2] - wc_q[1] != 1)
                $display("FAIL b2b_spacing got %0d %0d exp 1 1",
                         wc_q[1] - wc_q[0], wc_q[2] - wc_q[1]);
            else n_pass++;
        end
    endtask

    task automatic test_b_j();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        set_fields(3, 7'h63, 0, 0, 1, 2, 0, 32'hFFFFFFFC);
        send_cur("beq");
        set_fields(5, 7'h6F, 0, 0, 0, 0, 1, 32'd8);
        send_cur("jal");
        drain("bj");
        n_checks++;
        if (wd_q.size() != 2 || wd_q[0] !== 32'hFE208EE3 || wa_q[0] !== 10'd3)
            $display("FAIL beq got n %0d data %h addr %0d exp fe208ee3 3",
                     wd_q.size(), wd_q[0], wa_q[0]);
        else n_pass++;
        n_checks++;
        if (wd_q.size() != 2 || wd_q[1] !== 32'h008000EF || wa_q[1] !== 10'd4)
            $display("FAIL jal got data %h addr %0d exp 008000ef 4",
                     wd_q[1], wa_q[1]);
        else n_pass++;
    endtask

    task automatic test_start_with_bundle();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        set_fields(1, 7'h13, 0, 0, 2, 0, 7, 32'h7FF);
        start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        drain("start_bundle");
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'h7FF10393)
            $display("FAIL start_bundle got n %0d addr %0d data %h exp 1 0 7ff10393",
                     wa_q.size(), wa_q[0], wd_q[0]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit lg;
        logic [31:0] w0;
        new_session();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_fields(0, lg);
            exp_q.push_back(cur_exp());
            send_cur("bp_fill");
        end
        rand_fields(0, lg);
        exp_q.push_back(cur_exp());
        w0 = exp_q[0];
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", in_ready);
        else n_pass++;
        n_checks++;
        if (mem_we !== 1'b1 || mem_wdata !== w0 || mem_addr !== 10'd0)
            $display("FAIL bp_head got we %b data %h addr %0d exp 1 %h 0",
                     mem_we, mem_wdata, mem_addr, w0);
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || mem_wdata !== w0 || mem_addr !== 10'd0)
            $display("FAIL bp_hold got rdy %b data %h addr %0d exp 0 %h 0",
                     in_ready, mem_wdata, mem_addr, w0);
        else n_pass++;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_reopen got %b exp 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("bp");
        n_checks++;
        if (wa_q.size() != 5) $display("FAIL bp_n got %0d exp 5", wa_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_q[i])
                $display("FAIL bp_word%0d got %0d %h exp %0d %h",
                         i, wa_q[i], wd_q[i], i, exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (count !== 11'd5) $display("FAIL bp_count got %0d exp 5", count);
        else n_pass++;
    endtask

    task automatic test_illegal_and_start();
        new_session();
        mem_ready = 1'b1;
        set_fields(0, 7'h33, 0, 0, 1, 2, 3, 0);
        send_cur("il_pre");
        drain("il_pre");
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        set_fields(7, 7'h33, 0, 0, 1, 2, 3, 0);
        send_cur("il_bad");
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1) $display("FAIL il_err got %b exp 1", err);
        else n_pass++;
        n_checks++;
        if (wa_q.size() != 0 || count !== 11'd1 || busy !== 1'b0)
            $display("FAIL il_nowrite got n %0d cnt %0d busy %b exp 0 1 0",
                     wa_q.size(), count, busy);
        else n_pass++;
        mem_ready = 1'b0;
        set_fields(1, 7'h13, 0, 0, 0, 0, 1, 32'd5);
        send_cur("il_busy");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (err !== 1'b1 || count !== 11'd1 || mem_addr !== 10'd1)
            $display("FAIL start_busy got err %b cnt %0d addr %0d exp 1 1 1",
                     err, count, mem_addr);
        else n_pass++;
        mem_ready = 1'b1;
        drain("il_busy");
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 10'd1 || count !== 11'd2)
            $display("FAIL il_after got n %0d addr %0d cnt %0d exp 1 1 2",
                     wa_q.size(), wa_q[0], count);
        else n_pass++;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0 || count !== 11'd0 || mem_addr !== 10'd0)
            $display("FAIL start_idle got err %b cnt %0d addr %0d exp 0 0 0",
                     err, count, mem_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        bit lg;
        bit any_bad;
        int bad_mm;
        any_bad = 0;
        new_session();
        rnd_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            rand_fields(1, lg);
            if (lg) exp_q.push_back(cur_exp());
            else any_bad = 1;
            send_cur("rnd");
        end
        rnd_rdy = 0;
        @(posedge clk); #2;
        mem_ready = 1'b1;
        drain("rnd");
        n_checks++;
        if (wd_q.size() != exp_q.size())
            $display("FAIL rnd_n got %0d exp %0d", wd_q.size(), exp_q.size());
        else n_pass++;
        bad_mm = 0;
        for (int i = 0; i < wd_q.size() && i < exp_q.size(); i++) begin
            if (wd_q[i] !== exp_q[i] || wa_q[i] !== 10'(i)) begin
                if (bad_mm == 0)
                    $display("FAIL rnd_word%0d got %0d %h exp %0d %h",
                             i, wa_q[i], wd_q[i], i, exp_q[i]);
                bad_mm++;
            end
        end
        n_checks++;
        if (bad_mm != 0) $display("FAIL rnd_words bad %0d exp 0", bad_mm);
        else n_pass++;
        n_checks++;
        if (count !== 11'(exp_q.size()) || err !== any_bad)
            $display("FAIL rnd_state got cnt %0d err %b exp %0d %b",
                     count, err, exp_q.size(), any_bad);
        else n_pass++;
    endtask

    task automatic test_wrap_saturate();
        bit lg;
        int bad_mm;
        new_session();
        mem_ready = 1'b1;
        for (int i = 0; i < 2050; i++) begin
            rand_fields(0, lg);
            exp_q.push_back(cur_exp());
            send_cur("wrap");
        end
        drain("wrap");
        n_checks++;
        if (wd_q.size() != 2050) $display("FAIL wrap_n got %0d exp 2050", wd_q.size());
        else n_pass++;
        bad_mm = 0;
        for (int i = 0; i < wd_q.size() && i < 2050; i++) begin
            if (wd_q[i] !== exp_q[i] || wa_q[i] !== 10'(i % 1024)) bad_mm++;
        end
        n_checks++;
        if (bad_mm != 0) $display("FAIL wrap_words bad %0d exp 0", bad_mm);
        else n_pass++;
        n_checks++;
        if (count !== 11'h7FF || mem_addr !== 10'd2)
            $display("FAIL wrap_sat got cnt %0d addr %0d exp 2047 2",
                     count, mem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit lg;
        new_session();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields(0, lg);
            send_cur("rstmid");
        end
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rstmid_inrst got we %b rdy %b exp 0 0", mem_we, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || count !== 11'd0 || mem_addr !== 10'd0)
            $display("FAIL rstmid_after got busy %b we %b cnt %0d addr %0d exp 0 0 0 0",
                     busy, mem_we, count, mem_addr);
        else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (wa_q.size() != 0) $display("FAIL rstmid_writes got %0d exp 0", wa_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_r();
        test_back_to_back();
        test_b_j();
        test_start_with_bundle();
        test_backpressure();
        test_illegal_and_start();
        test_random();
        test_wrap_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Assembles RV32I instructions from individual fields and streams the resulting 32-bit words into instruction memory at auto-incrementing word addresses. It is the field-to-word counterpart of the pipeline's field-extraction decoder. It sits between a test/boot program source (bench sequencer or loader FSM) and the instruction memory write port. A small FIFO decouples field submission from memory backpressure.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width of the memory write port
- BASE_ADDR, 0, first word address after reset or `start`
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin new load session
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_rs1, in_rs2, in_rd  in  `REG_ADDR_WIDTH (5)  register addresses
- in_imm  in  `DATA_WIDTH (32)  immediate, byte-offset form (B/J), full 32-bit value (U)
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  `DATA_WIDTH  encoded instruction
- busy  out  1  FIFO non-empty
- count  out  ADDR_WIDTH+1  words written this session, saturating
- err  out  1  sticky illegal-format flag

## Operation
Encoding (msb→lsb), applied combinationally on acceptance:
- R: funct7|rs2|rs1|funct3|rd|opcode
- I: imm[11:0]|rs1|funct3|rd|opcode
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
- U: imm[31:12]|rd|opcode
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Unused fields for a format are ignored; imm bits not listed are dropped, with no range check.

Behaviour:
- Accepted legal bundle: encoded word pushed to FIFO.
- Accepted illegal fmt (6,7): nothing pushed; err set; err stays set until rst or accepted `start`.
- Write side: mem_we = FIFO non-empty; mem_wdata = FIFO head. On mem_we && mem_ready: pop, mem_addr += 1 (wraps modulo 2^ADDR_WIDTH), count += 1 (saturates at all-ones).
- in_ready = !full && !rst. Push and pop in the same cycle are allowed at any non-full occupancy.
- `start`: honoured only when FIFO is empty. It sets mem_addr=BASE_ADDR, count=0, err=0. It is ignored while busy. If in_valid is also high in that cycle, the bundle is accepted and becomes the first word of the new session.

Reset values: in_ready=0 during rst and 1 the cycle after; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; busy=0; count=0; err=0. Reset mid-operation discards all FIFO contents; no write is issued in the reset cycle.

## Timing
- Bundle accepted at edge N → mem_we high, with its word on mem_wdata, from cycle N+1 (one-cycle latency through the FIFO).
- mem_wdata and mem_addr hold stable while mem_we && !mem_ready.
- Sustained throughput is one word per cycle when mem_ready is held high.
- Full FIFO: in_ready is low in the cycle after the FIFO_DEPTH-th push without a pop, and returns high in the cycle after the first pop.
- Words are written in acceptance order and never reordered.

## Test plan
- R add x3,x1,x2 (op 0x33, f3 0, f7 0) with mem_ready=1 → one write, addr 0, data 0x002081B3, count=1.
- I addi x1,x0,5 → 0x00500093; S sw x2,8(x1) → 0x0020A423; U lui x5,imm 0x12345000 → 0x123452B7. These are back-to-back, giving addrs 0,1,2 on consecutive cycles.
- B beq x1,x2,imm −4 → 0xFE208EE3; J jal x1,imm 8 → 0x008000EF.
- mem_ready=0 while 5 bundles are offered → in_ready drops after the 4th. Then mem_ready=1 → 5 writes at addrs 0–4 in order, count=5.
- in_fmt=7 → err=1, no mem_we, count unchanged. `start` while busy is ignored. `start` when idle → err=0, count=0, addr=BASE_ADDR.
- ADDR_WIDTH=2, 5 writes → addrs 0,1,2,3,0. Assert rst with 3 words queued → busy=0 and mem_we=0 next cycle, with no further writes.
